onfi_sdr_target_model: RTL and testbench



---
 rtl/onfi_sdr_target_model.sv | 243 ++++++++++++++++++++++++
 tb/tb_onfi_sdr_target_model.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/onfi_sdr_target_model.sv
// ONFI SDR (asynchronous interface) NAND target model.
// Oversamples the host control pins on clk, decodes RESET / READ ID /
// READ STATUS / READ PAGE and answers on DQ with ID bytes, status or a
// column^row data pattern (there is no array storage).
// Ports:
//   clk, rst          oversampling clock, async active-high reset
//   CE_x_n .. WP_x_n  host control pins (asynchronous to clk)
//   dq_in             DQ pad input (cmd/addr on [7:0])
//   dq_out, dq_oe     DQ pad output value and output enable
//   RB_x_n            ready/busy#, 0 = busy
module onfi_sdr_target_model #(
  parameter int          IO_W       = 8,
  parameter int          COL_CYC    = 2,
  parameter int          ROW_CYC    = 3,
  parameter int          ID_BYTES   = 5,
  parameter logic [63:0] ID_VALUE   = 64'h0000_002C_D390_A12C,
  parameter int          T_R_CYC    = 64,
  parameter int          T_RST_CYC  = 16,
  parameter int          PAGE_BYTES = 2048
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            CE_x_n,
  input  logic            CLE_x,
  input  logic            ALE_x,
  input  logic            WE_x_n,
  input  logic            RE_x_n,
  input  logic            WP_x_n,
  input  logic [IO_W-1:0] dq_in,
  output logic [IO_W-1:0] dq_out,
  output logic            dq_oe,
  output logic            RB_x_n
);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ID_ADDR, S_ID_OUT, S_STATUS_OUT,
    S_RD_ADDR, S_RD_CONF, S_BUSY, S_DATA_OUT
  } state_t;

  // Control pins packed {CE,CLE,ALE,WE,RE,WP}; reset to the idle pin levels.
  localparam logic [5:0] CTL_IDLE = 6'b100111;

  logic [5:0]      r_ctl_s1, r_ctl_s2;
  logic [7:0]      r_dq_s1, r_dq_s2;
  logic            r_ce_d, r_we_d, r_re_d;
  logic            w_ce, w_cle, w_ale, w_we, w_re, w_wp;
  logic            w_we_rise, w_re_rise, w_ce_rise;

  logic            r_lat_vld, r_lat_cmd;
  logic [7:0]      r_lat_byte;

  state_t          r_state, w_nxt_state;
  state_t          r_prev, w_nxt_prev;    // state resumed after STATUS_OUT
  state_t          r_after, w_nxt_after;  // state entered when busy ends
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [15:0]     r_col, w_nxt_col;
  logic [23:0]     r_row, w_nxt_row;
  logic [2:0]      r_acnt, w_nxt_acnt;
  logic [3:0]      r_idx, w_nxt_idx;

  // 2-flop synchronisers; dq rides an equal-depth path so it lines up with WE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctl_s1 <= CTL_IDLE;
      r_ctl_s2 <= CTL_IDLE;
      r_dq_s1  <= '0;
      r_dq_s2  <= '0;
      r_ce_d   <= 1'b1;
      r_we_d   <= 1'b1;
      r_re_d   <= 1'b1;
    end else begin
      r_ctl_s1 <= {CE_x_n, CLE_x, ALE_x, WE_x_n, RE_x_n, WP_x_n};
      r_ctl_s2 <= r_ctl_s1;
      r_dq_s1  <= dq_in[7:0];
      r_dq_s2  <= r_dq_s1;
      r_ce_d   <= w_ce;
      r_we_d   <= w_we;
      r_re_d   <= w_re;
    end
  end

  assign {w_ce, w_cle, w_ale, w_we, w_re, w_wp} = r_ctl_s2;
  assign w_we_rise = w_we & ~r_we_d;
  assign w_re_rise = w_re & ~r_re_d;
  assign w_ce_rise = w_ce & ~r_ce_d;

  // Cmd/addr byte is registered here and acted on one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_vld  <= 1'b0;
      r_lat_cmd  <= 1'b0;
      r_lat_byte <= '0;
    end else begin
      r_lat_vld  <= w_we_rise & ~w_ce & (w_cle ^ w_ale);
      r_lat_cmd  <= w_cle;
      r_lat_byte <= r_dq_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_prev  <= S_IDLE;
      r_after <= S_IDLE;
      r_cnt   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_acnt  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_prev  <= w_nxt_prev;
      r_after <= w_nxt_after;
      r_cnt   <= w_nxt_cnt;
      r_col   <= w_nxt_col;
      r_row   <= w_nxt_row;
      r_acnt  <= w_nxt_acnt;
      r_idx   <= w_nxt_idx;
    end
  end

  logic w_busy;
  int   w_ri;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_prev  = r_prev;
    w_nxt_after = r_after;
    w_nxt_cnt   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
    w_nxt_col   = r_col;
    w_nxt_row   = r_row;
    w_nxt_acnt  = r_acnt;
    w_nxt_idx   = r_idx;
    w_busy      = 1'b0;
    w_ri        = 0;

    // Busy timer expiry, also while the host is polling status.
    if (r_cnt == CNT_W'(1)) begin
      if (r_state == S_BUSY) w_nxt_state = r_after;
      if (r_state == S_STATUS_OUT && r_prev == S_BUSY) w_nxt_prev = r_after;
    end

    if (w_re_rise && !w_ce) begin
      if (r_state == S_ID_OUT && r_idx < 4'(ID_BYTES)) w_nxt_idx = r_idx + 1'b1;
      if (r_state == S_DATA_OUT)
        w_nxt_col = (r_col >= 16'(PAGE_BYTES - 1)) ? '0 : r_col + 1'b1;
    end

    // Deselect aborts address/output sequences; a pending busy survives.
    if (w_ce_rise) begin
      case (r_state)
        S_ID_ADDR, S_ID_OUT, S_RD_ADDR, S_RD_CONF, S_DATA_OUT: w_nxt_state = S_IDLE;
        S_STATUS_OUT: w_nxt_state = (w_nxt_prev == S_BUSY) ? S_BUSY : S_IDLE;
        default: ;
      endcase
    end

    w_busy = (w_nxt_state == S_BUSY) ||
             (w_nxt_state == S_STATUS_OUT && w_nxt_prev == S_BUSY);

    if (r_lat_vld) begin
      if (r_lat_cmd) begin
        if (r_lat_byte == 8'hFF) begin
          w_nxt_state = S_BUSY;
          w_nxt_after = S_IDLE;
          w_nxt_prev  = S_IDLE;
          w_nxt_cnt   = CNT_W'(T_RST_CYC);
        end else if (r_lat_byte == 8'h70) begin
          if (w_nxt_state != S_STATUS_OUT) w_nxt_prev = w_nxt_state;
          w_nxt_state = S_STATUS_OUT;
        end else if (w_busy) begin
          // only RESET and STATUS are honoured while busy
        end else if (w_nxt_state == S_STATUS_OUT && r_lat_byte == 8'h00 &&
                     w_nxt_prev == S_DATA_OUT) begin
          w_nxt_state = S_DATA_OUT;
        end else begin
          case (r_lat_byte)
            8'h90: w_nxt_state = S_ID_ADDR;
            8'h00: begin
              w_nxt_state = S_RD_ADDR;
              w_nxt_acnt  = '0;
              w_nxt_col   = '0;
              w_nxt_row   = '0;
            end
            8'h30: begin
              if (w_nxt_state == S_RD_CONF) begin
                w_nxt_state = S_BUSY;
                w_nxt_after = S_DATA_OUT;
                w_nxt_cnt   = CNT_W'(T_R_CYC);
              end else begin
                w_nxt_state = S_IDLE;
              end
            end
            default: w_nxt_state = S_IDLE;
          endcase
        end
      end else if (!w_busy) begin
        case (w_nxt_state)
          S_ID_ADDR: begin
            w_nxt_state = (r_lat_byte == 8'h00) ? S_ID_OUT : S_IDLE;
            w_nxt_idx   = '0;
          end
          S_RD_ADDR: begin
            // column bytes first, then row bytes, each LSB byte first
            if (int'(r_acnt) < COL_CYC) begin
              w_nxt_col[8*r_acnt +: 8] = r_lat_byte;
            end else begin
              w_ri = int'(r_acnt) - COL_CYC;
              w_nxt_row[8*w_ri +: 8] = r_lat_byte;
            end
            w_nxt_acnt = r_acnt + 1'b1;
            if (int'(r_acnt) == COL_CYC + ROW_CYC - 1) w_nxt_state = S_RD_CONF;
          end
          S_RD_CONF: w_nxt_state = S_IDLE;
          default: ;
        endcase
      end
    end
  end

  logic [63:0] w_id_sh;
  logic        w_rdy;
  assign w_id_sh = ID_VALUE >> {r_idx, 3'b000};
  assign w_rdy   = (r_cnt == '0);
  assign RB_x_n  = w_rdy;
  assign dq_oe   = ~w_ce & ~w_re &
                   (r_state == S_ID_OUT || r_state == S_STATUS_OUT || r_state == S_DATA_OUT);

  always_comb begin
    dq_out = '0;
    case (r_state)
      S_ID_OUT:     if (r_idx < 4'(ID_BYTES)) dq_out[7:0] = w_id_sh[7:0];
      S_STATUS_OUT: dq_out[7:0] = {w_wp, w_rdy, w_rdy, 5'b00000};
      S_DATA_OUT: begin
        dq_out[7:0] = r_col[7:0] ^ r_row[7:0];
        if (IO_W > 8) dq_out[IO_W-1 -: 8] = r_col[7:0] ^ r_row[15:8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_onfi_sdr_target_model.sv
module tb_onfi_sdr_target_model;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       CE_x_n = 1'b1, CLE_x = 1'b0, ALE_x = 1'b0;
  logic       WE_x_n = 1'b1, RE_x_n = 1'b1, WP_x_n = 1'b1;
  logic [7:0] dq_in = '0;
  logic [7:0] dq_out;
  logic       dq_oe, RB_x_n;

  int total = 0;
  int bad   = 0;

  onfi_sdr_target_model dut (
    .clk(clk), .rst(rst), .CE_x_n(CE_x_n), .CLE_x(CLE_x), .ALE_x(ALE_x),
    .WE_x_n(WE_x_n), .RE_x_n(RE_x_n), .WP_x_n(WP_x_n), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .RB_x_n(RB_x_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One WE pulse latching a command (c=1) or address byte.
  task automatic wr(input bit c, input logic [7:0] b);
    CE_x_n = 1'b0; CLE_x = c; ALE_x = ~c; dq_in = b;
    WE_x_n = 1'b0; clks(3);
    WE_x_n = 1'b1; clks(2);
    CLE_x = 1'b0; ALE_x = 1'b0;
  endtask

  // RE pulse; samples DQ and OE while RE is low.
  task automatic rd(output logic [7:0] b, output logic oe);
    RE_x_n = 1'b0; clks(4);
    b = dq_out; oe = dq_oe;
    RE_x_n = 1'b1; clks(4);
  endtask

  // Counts clocks RB_x_n is low; bounded waits.
  task automatic busy_len(output int n);
    int t;
    n = 0; t = 0;
    while (RB_x_n && t < 20) begin @(negedge clk); t++; end
    while (!RB_x_n && n < 500) begin @(negedge clk); n++; end
  endtask

  task automatic read_page(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] r0);
    wr(1, 8'h00);
    wr(0, c0); wr(0, c1); wr(0, r0); wr(0, 8'h00); wr(0, 8'h00);
    wr(1, 8'h30);
  endtask

  logic [7:0] b;
  logic       oe;
  int         n;
  logic [7:0] id_exp [6] = '{8'h2C, 8'hA1, 8'h90, 8'hD3, 8'h2C, 8'h00};

  initial begin
    clks(3);
    chk("rst_oe", 16'(dq_oe), 16'd0);
    chk("rst_rb", 16'(RB_x_n), 16'd1);
    chk("rst_dq", 16'(dq_out), 16'd0);
    rst = 1'b0;
    clks(3);

    // READ ID, one extra pulse past the last byte
    wr(1, 8'h90); wr(0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      rd(b, oe);
      chk($sformatf("id%0d", i), 16'(b), 16'(id_exp[i]));
      chk($sformatf("id_oe%0d", i), 16'(oe), 16'd1);
    end

    // RESET busy length
    wr(1, 8'hFF);
    busy_len(n);
    chk("rst_busy", 16'(n), 16'd16);

    // Status during and after reset busy
    wr(1, 8'hFF); wr(1, 8'h70);
    chk("st_rb_low", 16'(RB_x_n), 16'd0);
    rd(b, oe);
    chk("st_busy", 16'(b), 16'h80);
    chk("st_oe", 16'(oe), 16'd1);
    busy_len(n);
    rd(b, oe);
    chk("st_ready", 16'(b), 16'hE0);
    WP_x_n = 1'b0; clks(4);
    rd(b, oe);
    chk("st_wp0", 16'(b), 16'h60);
    WP_x_n = 1'b1;

    // READ PAGE col=5 row=3
    read_page(8'h05, 8'h00, 8'h03);
    busy_len(n);
    chk("rd_busy", 16'(n), 16'd64);
    rd(b, oe); chk("rd0", 16'(b), 16'h06); chk("rd_oe", 16'(oe), 16'd1);
    rd(b, oe); chk("rd1", 16'(b), 16'h05);
    rd(b, oe); chk("rd2", 16'(b), 16'h04);

    // Column wrap at end of page
    read_page(8'hFF, 8'h07, 8'h03);
    busy_len(n);
    rd(b, oe); chk("wrap0", 16'(b), 16'hFC);
    rd(b, oe); chk("wrap1", 16'(b), 16'h03);

    // Deselect mid-address aborts; confirm then ignored
    wr(1, 8'h00); wr(0, 8'h05); wr(0, 8'h00);
    CE_x_n = 1'b1; clks(6); CE_x_n = 1'b0; clks(2);
    wr(1, 8'h30);
    n = 0;
    for (int i = 0; i < 80; i++) begin @(negedge clk); if (!RB_x_n) n++; end
    chk("abort_rb", 16'(n), 16'd0);
    rd(b, oe);
    chk("abort_oe", 16'(oe), 16'd0);
    chk("abort_dq", 16'(b), 16'd0);

    // Async reset in the middle of DATA_OUT
    read_page(8'h10, 8'h00, 8'h01);
    busy_len(n);
    RE_x_n = 1'b0; clks(4);
    chk("pre_rst_oe", 16'(dq_oe), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_oe", 16'(dq_oe), 16'd0);
    chk("mid_rst_rb", 16'(RB_x_n), 16'd1);
    chk("mid_rst_dq", 16'(dq_out), 16'd0);
    clks(2); rst = 1'b0; RE_x_n = 1'b1; clks(4);
    wr(1, 8'h90); wr(0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      rd(b, oe);
      chk($sformatf("id_post%0d", i), 16'(b), 16'(id_exp[i]));
    end

    // Non-zero READ ID address goes nowhere
    wr(1, 8'h90); wr(0, 8'h20);
    rd(b, oe);
    chk("id_badaddr_oe", 16'(oe), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
